// File: rtl/pll_rs_reset_seq.sv
`timescale 1ns/1ps
// Reset sequencer behind the Reed-Solomon PLL: pulses the PLL reset, waits for a
// stable synchronized lock, holds the core in reset for a hold-off, then releases it.
module pll_rs_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES        = 64,
  parameter int LOCK_TIMEOUT       = 65536
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int RW = $clog2(PLL_RST_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [RW-1:0] RST_LAST    = RW'(PLL_RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_DONE = SW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [RW-1:0]          rst_cnt;
  logic [SW-1:0]          stable_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic [HW-1:0]          hold_cnt;
  logic                   entry;
  logic                   retry_inc;
  logic                   loss_inc;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Stable count is compared as a registered value, so HOLD is entered one edge
  // after the last counted locked sample; soft request overrides every state.
  always_comb begin
    state_n   = state;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    if (soft_rst_req) begin
      state_n = S_PLL_RST;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (rst_cnt == RST_LAST) state_n = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (stable_cnt == STABLE_DONE) begin
            state_n = S_HOLD;
          end else if (tmo_cnt == TMO_LAST) begin
            state_n   = S_PLL_RST;
            retry_inc = 1'b1;
          end
        end
        S_HOLD: begin
          if (!locked_s) state_n = S_WAIT_LOCK;
          else if (hold_cnt == HOLD_LAST) state_n = S_RUN;
        end
        S_RUN: begin
          if (!locked_s) begin
            state_n  = S_WAIT_LOCK;
            loss_inc = 1'b1;
          end
        end
        default: state_n = S_PLL_RST;
      endcase
    end
    entry = soft_rst_req || (state_n != state);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= S_PLL_RST;
      sync_q     <= '0;
      rst_cnt    <= '0;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      hold_cnt   <= '0;
      retry_cnt  <= '0;
      loss_cnt   <= '0;
      pll_rst    <= 1'b1;
      core_rst   <= 1'b1;
      ready      <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state    <= state_n;
      pll_rst  <= (state_n == S_PLL_RST);
      core_rst <= (state_n != S_RUN);
      ready    <= (state_n == S_RUN);

      if (retry_inc && (retry_cnt != 4'd15)) retry_cnt <= retry_cnt + 4'd1;
      if (loss_inc && (loss_cnt != 8'd255)) loss_cnt <= loss_cnt + 8'd1;

      if (entry) begin
        rst_cnt    <= '0;
        stable_cnt <= '0;
        tmo_cnt    <= '0;
        hold_cnt   <= '0;
      end else begin
        case (state)
          S_PLL_RST: rst_cnt <= rst_cnt + RW'(1);
          S_WAIT_LOCK: begin
            tmo_cnt    <= tmo_cnt + TW'(1);
            stable_cnt <= locked_s ? stable_cnt + SW'(1) : '0;
          end
          S_HOLD: hold_cnt <= hold_cnt + HW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_rs_reset_seq.sv
`timescale 1ns/1ps
// Self-checking bench for pll_rs_reset_seq: a table of nominal/loss/soft/glitch
// vectors, hand sequences for retry and loss saturation and async reset, then random lock traffic.
module tb_pll_rs_reset_seq;

  localparam int P    = 4;
  localparam int L    = 8;
  localparam int H    = 4;
  localparam int T    = 32;
  localparam int SYNC = 2;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_RUN  = 3;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       soft_rst_req;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  pll_rs_reset_seq #(
    .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(P), .LOCK_STABLE_CYCLES(L),
    .HOLD_CYCLES(H), .LOCK_TIMEOUT(T)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .pll_rst(pll_rst), .core_rst(core_rst), .ready(ready),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  // clock / reset block
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference model: timestamps of phase entry and of the last unlocked sample
  int k;
  int m_phase;
  int t_entry;
  int low_mark;
  int m_retry;
  int m_loss;
  int hist[$];

  task automatic model_reset();
    k = 0; m_phase = PH_RST; t_entry = 0; low_mark = 0; m_retry = 0; m_loss = 0;
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(0);
  endtask

  task automatic model_edge(input int lk, input int sr);
    int ls;
    int nxt;
    k++;
    ls = hist.pop_front();
    hist.push_back(lk);
    nxt = m_phase;
    if (sr != 0) begin
      nxt = PH_RST;
    end else begin
      case (m_phase)
        PH_RST: if (k - t_entry == P) nxt = PH_WAIT;
        PH_WAIT: begin
          if (k - 1 - low_mark == L) nxt = PH_HOLD;
          else if (k - t_entry == T) begin
            nxt = PH_RST;
            if (m_retry < 15) m_retry++;
          end
          if (ls == 0) low_mark = k;
        end
        PH_HOLD: begin
          if (ls == 0) nxt = PH_WAIT;
          else if (k - t_entry == H) nxt = PH_RUN;
        end
        default: begin
          if (ls == 0) begin
            nxt = PH_WAIT;
            if (m_loss < 255) m_loss++;
          end
        end
      endcase
    end
    if ((sr != 0) || (nxt != m_phase)) begin
      t_entry  = k;
      low_mark = k;
    end
    m_phase = nxt;
  endtask

  // driver tasks
  task automatic tick(input int lk, input int sr);
    pll_locked   = lk[0];
    soft_rst_req = sr[0];
    @(posedge refclk);
    model_edge(lk, sr);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pll_locked = 1'b0; soft_rst_req = 1'b0;
    #2;
    check("rst pll_rst", int'(pll_rst), 1);
    check("rst core_rst", int'(core_rst), 1);
    check("rst ready", int'(ready), 0);
    check("rst retry_cnt", int'(retry_cnt), 0);
    check("rst loss_cnt", int'(loss_cnt), 0);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    check({tag, " pll_rst"}, int'(pll_rst), (m_phase == PH_RST) ? 1 : 0);
    check({tag, " core_rst"}, int'(core_rst), (m_phase != PH_RUN) ? 1 : 0);
    check({tag, " ready"}, int'(ready), (m_phase == PH_RUN) ? 1 : 0);
    check({tag, " retry_cnt"}, int'(retry_cnt), m_retry);
    check({tag, " loss_cnt"}, int'(loss_cnt), m_loss);
  endtask

  typedef struct {
    int n;
    int lk;
    int sr;
    int pll;
    int core;
    int rdy;
    int retry;
    int loss;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  initial begin
    int remaining;
    int lvl;
    int sr;
    int exp_retry;

    // edge numbers after rst release: lock raised at 10, lost 25..27, soft at 43, glitch at 54
    vecs[0]  = '{3,  0, 0, 1, 1, 0, 0, 0};
    vecs[1]  = '{1,  0, 0, 0, 1, 0, 0, 0};
    vecs[2]  = '{5,  0, 0, 0, 1, 0, 0, 0};
    vecs[3]  = '{13, 1, 0, 0, 1, 0, 0, 0};
    vecs[4]  = '{1,  1, 0, 0, 1, 0, 0, 0};
    vecs[5]  = '{1,  1, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{1,  0, 0, 0, 0, 1, 0, 0};
    vecs[7]  = '{1,  0, 0, 0, 0, 1, 0, 0};
    vecs[8]  = '{1,  0, 0, 0, 1, 0, 0, 1};
    vecs[9]  = '{13, 1, 0, 0, 1, 0, 0, 1};
    vecs[10] = '{1,  1, 0, 0, 1, 0, 0, 1};
    vecs[11] = '{1,  1, 0, 0, 0, 1, 0, 1};
    vecs[12] = '{1,  0, 1, 1, 1, 0, 0, 1};
    vecs[13] = '{4,  0, 0, 0, 1, 0, 0, 1};
    vecs[14] = '{6,  1, 0, 0, 1, 0, 0, 1};
    vecs[15] = '{1,  0, 0, 0, 1, 0, 0, 1};
    vecs[16] = '{7,  1, 0, 0, 1, 0, 0, 1};
    vecs[17] = '{1,  1, 0, 0, 1, 0, 0, 1};
    vecs[18] = '{6,  1, 0, 0, 1, 0, 0, 1};
    vecs[19] = '{1,  1, 0, 0, 0, 1, 0, 1};

    do_reset();

    for (int v = 0; v < NV; v++) begin
      for (int j = 0; j < vecs[v].n; j++) tick(vecs[v].lk, vecs[v].sr);
      check($sformatf("vec%0d pll_rst", v), int'(pll_rst), vecs[v].pll);
      check($sformatf("vec%0d core_rst", v), int'(core_rst), vecs[v].core);
      check($sformatf("vec%0d ready", v), int'(ready), vecs[v].rdy);
      check($sformatf("vec%0d retry_cnt", v), int'(retry_cnt), vecs[v].retry);
      check($sformatf("vec%0d loss_cnt", v), int'(loss_cnt), vecs[v].loss);
    end

    // timeout retry: pulse every 36 edges, 4 edges wide, retry_cnt saturating
    do_reset();
    for (int r = 1; r <= 16; r++) begin
      while (k < 36 * r - 1) tick(0, 0);
      check($sformatf("retry%0d pre pll_rst", r), int'(pll_rst), 0);
      tick(0, 0);
      exp_retry = (r < 15) ? r : 15;
      check($sformatf("retry%0d pll_rst", r), int'(pll_rst), 1);
      check($sformatf("retry%0d retry_cnt", r), int'(retry_cnt), exp_retry);
      check($sformatf("retry%0d core_rst", r), int'(core_rst), 1);
      repeat (3) tick(0, 0);
      check($sformatf("retry%0d pulse end pll_rst", r), int'(pll_rst), 1);
      tick(0, 0);
      check($sformatf("retry%0d after pll_rst", r), int'(pll_rst), 0);
    end

    // lock loss in RUN, repeated past saturation
    do_reset();
    for (int i = 0; i < 200 && ready !== 1'b1; i++) tick(1, 0);
    check("bringup ready", int'(ready), 1);
    for (int i = 1; i <= 256; i++) begin
      tick(0, 0);
      tick(1, 0);
      tick(1, 0);
      check($sformatf("loss%0d core_rst", i), int'(core_rst), 1);
      check($sformatf("loss%0d pll_rst", i), int'(pll_rst), 0);
      check($sformatf("loss%0d loss_cnt", i), int'(loss_cnt), (i < 255) ? i : 255);
      repeat (13) tick(1, 0);
      check($sformatf("loss%0d relock ready", i), int'(ready), 1);
    end

    // soft request in RUN keeps counters; then one retry; then async reset mid-HOLD
    tick(1, 1);
    check("soft pll_rst", int'(pll_rst), 1);
    check("soft ready", int'(ready), 0);
    check("soft loss_cnt", int'(loss_cnt), 255);
    repeat (36) tick(0, 0);
    check("soft retry_cnt", int'(retry_cnt), 1);
    check("soft retry pll_rst", int'(pll_rst), 1);
    for (int i = 0; i < 200 && m_phase != PH_HOLD; i++) tick(1, 0);
    tick(1, 0);
    check("hold core_rst", int'(core_rst), 1);
    check("hold pll_rst", int'(pll_rst), 0);
    check("hold ready", int'(ready), 0);
    do_reset();

    // random lock traffic against the reference model
    remaining = 0;
    lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if (remaining == 0) begin
        lvl = 1 - lvl;
        remaining = (lvl != 0) ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 45));
      end
      remaining--;
      sr = ($urandom_range(0, 299) == 0) ? 1 : 0;
      tick(lvl, sr);
      check_model($sformatf("rnd@%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
